teclado_cajero: RTL

//  ATM keypad front-end: the transmitting end of the ATM controller's digit/amount interface.

---
 rtl/teclado_cajero.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/teclado_cajero.sv
// rtl/teclado_cajero.sv - ATM keypad front-end: debounce, PIN forwarding, amount entry
//
// Purpose:
//   Transmitting end of the ATM controller's digit/amount interface. Raw key
//   presses are debounced into single events. The four PIN digits are
//   forwarded one by one. The transaction type is captured next, then a decimal
//   amount is accumulated into binary. That amount is issued with monto_stb and
//   held, together with tipo_trans, until the controller closes the transaction.
//
// Ports:
//   CLK                   in   1   single clock, rising edge
//   RESET                 in   1   asynchronous, active-high reset
//   tarjeta_received      in   1   card inserted pulse, starts a session from idle
//   tecla_valida          in   1   raw key-down level from the keypad scanner
//   tecla_cod             in   4   0-9 digit, A=ENTER, B=BORRAR, C=DEPOSITO, D=RETIRO
//   pin_incorrecto        in   1   controller rejected the PIN, re-enter it
//   bloqueo               in   1   controller locked the card (level)
//   balance_stb           in   1   controller completed the transaction
//   fondos_insuficientes  in   1   controller refused the withdrawal
//   digito                out  4   PIN digit, valid while digito_stb=1
//   digito_stb            out  1   one-cycle PIN digit strobe
//   tipo_trans            out  1   0=deposit, 1=withdrawal
//   monto                 out  32  binary amount
//   monto_stb             out  1   one-cycle amount strobe
//   error_tecla           out  1   one-cycle pulse on a rejected key
//   n_digitos             out  4   digits entered in the current field

module teclado_cajero #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int MAX_MONTO_DIGITS = 9
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        tarjeta_received,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla_cod,
  input  logic        pin_incorrecto,
  input  logic        bloqueo,
  input  logic        balance_stb,
  input  logic        fondos_insuficientes,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic        tipo_trans,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        error_tecla,
  output logic [3:0]  n_digitos
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    ND_MAX   = 4'(MAX_MONTO_DIGITS);

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_BORRAR = 4'hB;
  localparam logic [3:0] K_DEP    = 4'hC;
  localparam logic [3:0] K_RET    = 4'hD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN,
    S_TIPO,
    S_MONTO,
    S_FIN,
    S_BLOQ
  } state_t;

  // ---------------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [3:0]    cod_prev;
  logic          armado;
  logic          key_evt;

  // cnt is the number of consecutive cycles, including the current one, in
  // which the same code has been held down. It saturates at CNT_FULL so a long
  // press cannot wrap around and fire a second time.
  always_comb begin
    cnt_next = cnt;
    if (!tecla_valida) begin
      cnt_next = '0;
    end else if ((cnt == '0) || (tecla_cod != cod_prev)) begin
      cnt_next = CNT_ONE;
    end else if (cnt != CNT_FULL) begin
      cnt_next = cnt + CNT_ONE;
    end
  end

  // The event fires only on the cycle that reaches CNT_FULL, and only while
  // armed. Arming requires a release, so a key held through reset, or held
  // after being accepted, produces no further events.
  assign key_evt = armado && tecla_valida && (cnt != CNT_FULL) && (cnt_next == CNT_FULL);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      cod_prev <= 4'h0;
      armado   <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      cod_prev <= tecla_cod;
      if (!tecla_valida) begin
        armado <= 1'b1;
      end else if (key_evt) begin
        armado <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Session FSM
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_n;
  logic [31:0] acc;
  logic [31:0] acc_n;
  logic [3:0]  n_digitos_n;
  logic [3:0]  digito_n;
  logic        digito_stb_n;
  logic        tipo_trans_n;
  logic [31:0] monto_n;
  logic        monto_stb_n;
  logic        error_tecla_n;

  logic        es_digito;
  logic [31:0] acc_mas_digito;

  assign es_digito      = (tecla_cod <= 4'd9);
  // At most nine decimal digits are ever accumulated, so this never overflows.
  assign acc_mas_digito = (acc * 32'd10) + {28'd0, tecla_cod};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      acc         <= 32'd0;
      n_digitos   <= 4'd0;
      digito      <= 4'd0;
      digito_stb  <= 1'b0;
      tipo_trans  <= 1'b0;
      monto       <= 32'd0;
      monto_stb   <= 1'b0;
      error_tecla <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      n_digitos   <= n_digitos_n;
      digito      <= digito_n;
      digito_stb  <= digito_stb_n;
      tipo_trans  <= tipo_trans_n;
      monto       <= monto_n;
      monto_stb   <= monto_stb_n;
      error_tecla <= error_tecla_n;
    end
  end

  // Each branch raises at most one of the three strobes, which keeps them
  // mutually exclusive. A key event that loses to bloqueo or pin_incorrecto is
  // simply not looked at; the debouncer has already disarmed, so it is dropped.
  always_comb begin
    state_n       = state;
    acc_n         = acc;
    n_digitos_n   = n_digitos;
    digito_n      = digito;
    digito_stb_n  = 1'b0;
    tipo_trans_n  = tipo_trans;
    monto_n       = monto;
    monto_stb_n   = 1'b0;
    error_tecla_n = 1'b0;

    if (bloqueo) begin
      state_n = S_BLOQ;
    end else if (pin_incorrecto &&
                 ((state == S_PIN) || (state == S_TIPO) || (state == S_MONTO))) begin
      state_n     = S_PIN;
      n_digitos_n = 4'd0;
      acc_n       = 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tarjeta_received) begin
            state_n     = S_PIN;
            n_digitos_n = 4'd0;
            acc_n       = 32'd0;
          end
        end

        S_PIN: begin
          // Digits are forwarded immediately, so there is nothing for BORRAR
          // to retract; non-digit keys are silently ignored here.
          if (key_evt && es_digito) begin
            digito_n     = tecla_cod;
            digito_stb_n = 1'b1;
            n_digitos_n  = n_digitos + 4'd1;
            if (n_digitos == 4'd3) begin
              state_n = S_TIPO;
            end
          end
        end

        S_TIPO: begin
          if (key_evt) begin
            if ((tecla_cod == K_DEP) || (tecla_cod == K_RET)) begin
              tipo_trans_n = (tecla_cod == K_RET);
              state_n      = S_MONTO;
              acc_n        = 32'd0;
              n_digitos_n  = 4'd0;
            end else if (tecla_cod <= K_BORRAR) begin
              error_tecla_n = 1'b1;
            end
          end
        end

        S_MONTO: begin
          if (key_evt) begin
            if (es_digito) begin
              if (n_digitos < ND_MAX) begin
                acc_n       = acc_mas_digito;
                n_digitos_n = n_digitos + 4'd1;
              end else begin
                error_tecla_n = 1'b1;
              end
            end else if (tecla_cod == K_BORRAR) begin
              acc_n       = 32'd0;
              n_digitos_n = 4'd0;
            end else if (tecla_cod == K_ENTER) begin
              if (n_digitos == 4'd0) begin
                error_tecla_n = 1'b1;
              end else begin
                monto_n     = acc;
                monto_stb_n = 1'b1;
                state_n     = S_FIN;
              end
            end else if ((tecla_cod == K_DEP) || (tecla_cod == K_RET)) begin
              error_tecla_n = 1'b1;
            end
          end
        end

        S_FIN: begin
          // monto and tipo_trans stay frozen until the controller answers.
          if (balance_stb || fondos_insuficientes) begin
            state_n      = S_IDLE;
            monto_n      = 32'd0;
            tipo_trans_n = 1'b0;
            acc_n        = 32'd0;
            n_digitos_n  = 4'd0;
          end
        end

        S_BLOQ: begin
          state_n = S_BLOQ;
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule
